ysyx_23060236_icache_refill: RTL and testbench

Fetch-side controller between the IFU and the memory bus. It looks up the instruction cache storage, answers hits locally, and on a miss runs an AXI4 INCR burst read that writes the whole 8-word line into the storage through its write port. Non-cacheable fetches go out as single-beat bypass reads. It is the writer and refill engine for the icache storage array, and the AXI read master on the fetch path.

---
 rtl/ysyx_23060236_icache_refill.sv | 145 ++++++++++++++
 tb/tb_ysyx_23060236_icache_refill.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_icache_refill.sv
// Fetch-side icache controller: answers hits from the storage array, refills
// missed lines with an AXI4 INCR burst, and forwards non-cacheable fetches as single beats.
module ysyx_23060236_icache_refill #(
   parameter int          ADDR_LEN   = 25,
   parameter int          OFFSET_LEN = 5,
   parameter logic [6:0]  CACHE_HI   = 7'h50
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ifu_arvalid,
   output logic                ifu_arready,
   input  logic [31:0]         ifu_araddr,
   output logic                ifu_rvalid,
   input  logic                ifu_rready,
   output logic [31:0]         ifu_rdata,
   output logic [1:0]          ifu_rresp,
   output logic [ADDR_LEN-1:0] icache_araddr,
   input  logic [31:0]         icache_rdata,
   input  logic                icache_hit,
   output logic [ADDR_LEN-1:0] icache_awaddr,
   output logic [31:0]         icache_wdata,
   output logic                icache_wvalid,
   output logic                arvalid,
   input  logic                arready,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   input  logic                rvalid,
   output logic                rready,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast
);

   localparam int                  WORD_BITS  = OFFSET_LEN - 2;
   localparam logic [7:0]          REFILL_LEN = 8'((1 << WORD_BITS) - 1);
   localparam logic [WORD_BITS-1:0] BEAT_ONE  = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_AR,
      S_R,
      S_RESP
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          addr_q, addr_d;
   logic [WORD_BITS-1:0] beat_q, beat_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [1:0]           resp_q, resp_d;
   logic                 cacheable_q, cacheable_d;

   assign icache_araddr = addr_q[ADDR_LEN-1:0];
   assign icache_awaddr = {addr_q[ADDR_LEN-1:OFFSET_LEN], beat_q, 2'b00};
   assign icache_wdata  = rdata;
   assign arsize        = 3'b010;
   assign arburst       = 2'b01;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         beat_q      <= '0;
         rdata_q     <= '0;
         resp_q      <= '0;
         cacheable_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         beat_q      <= beat_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         cacheable_q <= cacheable_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      beat_d        = beat_q;
      rdata_d       = rdata_q;
      resp_d        = resp_q;
      cacheable_d   = cacheable_q;
      ifu_arready   = 1'b0;
      ifu_rvalid    = 1'b0;
      ifu_rdata     = '0;
      ifu_rresp     = '0;
      arvalid       = 1'b0;
      araddr        = '0;
      arlen         = '0;
      rready        = 1'b0;
      icache_wvalid = 1'b0;
      case (state_q)
         S_IDLE: begin
            ifu_arready = 1'b1;
            if (ifu_arvalid) begin
               addr_d      = ifu_araddr;
               cacheable_d = (ifu_araddr[31:ADDR_LEN] == CACHE_HI);
               resp_d      = '0;
               state_d     = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cacheable_q && icache_hit) begin
               rdata_d = icache_rdata;
               state_d = S_RESP;
            end else begin
               beat_d  = '0;
               state_d = S_AR;
            end
         end
         S_AR: begin
            arvalid = 1'b1;
            araddr  = cacheable_q ? {addr_q[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}} : addr_q;
            arlen   = cacheable_q ? REFILL_LEN : 8'd0;
            if (arready) state_d = S_R;
         end
         S_R: begin
            rready = 1'b1;
            if (rvalid) begin
               resp_d = resp_q | rresp;
               if (cacheable_q) begin
                  // Error beats are written too; the fault travels back via ifu_rresp.
                  icache_wvalid = 1'b1;
                  beat_d        = beat_q + BEAT_ONE;
                  if (beat_q == addr_q[OFFSET_LEN-1:2]) rdata_d = rdata;
               end else begin
                  rdata_d = rdata;
               end
               if (rlast) state_d = S_RESP;
            end
         end
         S_RESP: begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = rdata_q;
            ifu_rresp  = resp_q;
            if (ifu_rready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060236_icache_refill.sv
// Directed bench for the icache refill controller: hit, refill, bypass,
// backpressure, error beat and mid-burst reset, with a small AXI memory responder.
module tb_ysyx_23060236_icache_refill;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
   logic [31:0] ifu_araddr, ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic [24:0] icache_araddr, icache_awaddr;
   logic [31:0] icache_rdata, icache_wdata;
   logic        icache_hit, icache_wvalid;
   logic        arvalid, arready, rvalid, rready, rlast;
   logic [31:0] araddr, rdata;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, rresp;

   ysyx_23060236_icache_refill dut (
      .clock(clock), .reset(reset),
      .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
      .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
      .icache_araddr(icache_araddr), .icache_rdata(icache_rdata), .icache_hit(icache_hit),
      .icache_awaddr(icache_awaddr), .icache_wdata(icache_wdata), .icache_wvalid(icache_wvalid),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   always #5 clock = ~clock;

   int          n_vec = 0;
   int          n_err = 0;
   int          wr_cnt, spur_cnt, ar_cnt, ar_unstable;
   logic [31:0] wr_addr [8];
   logic [31:0] wr_data [8];
   logic [31:0] ar_addr_obs;
   logic [7:0]  ar_len_obs;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // One complete fetch; the bench plays the AXI slave. rst_after >= 0 pulses
   // reset once that many beats have been delivered and abandons the fetch.
   task automatic do_fetch(input logic [31:0] a, input int ar_wait, input int gap,
                           input int err_beat, input int hold, input int rst_after,
                           input logic [31:0] base,
                           output logic [31:0] got_data, output logic [1:0] got_resp,
                           output int lat);
      int cyc, beats, gcnt;
      bit done;
      logic [24:0] low;
      low = a[24:0];
      wr_cnt = 0; spur_cnt = 0; ar_cnt = 0; ar_unstable = 0;
      ar_addr_obs = '0; ar_len_obs = '0;
      got_data = '0; got_resp = '0; lat = 0;
      ifu_arvalid = 1'b1;
      ifu_araddr  = a;
      @(negedge clock);
      ifu_arvalid = 1'b0;
      chk("lookup_addr", icache_araddr, low);
      chk("check_arready", ifu_arready, 1'b0);
      cyc = 1; beats = 0; gcnt = 0; done = 1'b0;
      while (!done && cyc < 100) begin
         @(negedge clock);
         cyc++;
         arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
         if (ifu_rvalid) begin
            done = 1'b1;
         end else if (arvalid) begin
            if (ar_cnt == 0) begin
               ar_addr_obs = araddr;
               ar_len_obs  = arlen;
            end else if (araddr !== ar_addr_obs || arlen !== ar_len_obs) begin
               ar_unstable++;
            end
            ar_cnt++;
            if (ar_cnt > ar_wait) arready = 1'b1;
         end else if (rready) begin
            if (rst_after >= 0 && beats == rst_after) begin
               reset = 1'b1;
               @(negedge clock);
               reset = 1'b0;
               rvalid = 1'b1;
               rdata  = 32'hdead_beef;
               #1;
               chk("rst_ifu_arready", ifu_arready, 1'b1);
               chk("rst_wvalid", icache_wvalid, 1'b0);
               chk("rst_rready", rready, 1'b0);
               chk("rst_arvalid", arvalid, 1'b0);
               chk("rst_ifu_rvalid", ifu_rvalid, 1'b0);
               rvalid = 1'b0;
               return;
            end
            if (gcnt < gap) begin
               gcnt++;
               #1;
               if (icache_wvalid) spur_cnt++;
            end else begin
               gcnt   = 0;
               rvalid = 1'b1;
               rdata  = base + 32'(beats);
               rresp  = (beats == err_beat) ? 2'b10 : 2'b00;
               rlast  = (beats == int'(ar_len_obs));
               #1;
               if (icache_wvalid && wr_cnt < 8) begin
                  wr_addr[wr_cnt] = 32'(icache_awaddr);
                  wr_data[wr_cnt] = icache_wdata;
                  wr_cnt++;
               end
               beats++;
            end
         end
      end
      if (!done) begin
         chk("timeout", 32'(cyc), 32'd0);
         return;
      end
      lat      = cyc;
      got_data = ifu_rdata;
      got_resp = ifu_rresp;
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         chk("hold_rvalid", ifu_rvalid, 1'b1);
         chk("hold_rdata", ifu_rdata, got_data);
      end
      ifu_rready = 1'b1;
      @(negedge clock);
      ifu_rready = 1'b0;
      chk("back_to_idle", ifu_arready, 1'b1);
   endtask

   logic [31:0] d;
   logic [1:0]  r;
   int          lat;

   initial begin
      reset = 1'b1; ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b0;
      icache_rdata = '0; icache_hit = 1'b0;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset state
      chk("rst_arready", ifu_arready, 1'b1);
      chk("rst_rvalid", ifu_rvalid, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_wvalid", icache_wvalid, 1'b0);
      chk("rst_rdata", ifu_rdata, 32'h0);
      chk("rst_rresp", ifu_rresp, 2'b00);
      chk("rst_araddr", araddr, 32'h0);
      chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, 2'b01);

      // Hit
      icache_hit = 1'b1; icache_rdata = 32'h0000_0413;
      do_fetch(32'ha000_0010, 0, 0, -1, 0, -1, 32'h0, d, r, lat);
      chk("hit_lat", 32'(lat), 32'd2);
      chk("hit_rdata", d, 32'h0000_0413);
      chk("hit_rresp", r, 2'b00);
      chk("hit_no_ar", 32'(ar_cnt), 32'd0);
      icache_hit = 1'b0; icache_rdata = 32'h0bad_0bad;

      // Miss refill, zero-wait memory
      do_fetch(32'ha000_0034, 0, 0, -1, 0, -1, 32'h1000, d, r, lat);
      chk("miss_araddr", ar_addr_obs, 32'ha000_0020);
      chk("miss_arlen", ar_len_obs, 8'd7);
      chk("miss_lat", 32'(lat), 32'd11);
      chk("miss_wcnt", 32'(wr_cnt), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("miss_awaddr", wr_addr[i], 32'h20 + 32'(4 * i));
         chk("miss_wdata", wr_data[i], 32'h1000 + 32'(i));
      end
      chk("miss_rdata", d, 32'h1005);
      chk("miss_rresp", r, 2'b00);

      // Bypass
      do_fetch(32'h3000_0008, 0, 0, -1, 0, -1, 32'h7700, d, r, lat);
      chk("byp_araddr", ar_addr_obs, 32'h3000_0008);
      chk("byp_arlen", ar_len_obs, 8'd0);
      chk("byp_wcnt", 32'(wr_cnt), 32'd0);
      chk("byp_rdata", d, 32'h7700);
      chk("byp_lat", 32'(lat), 32'd4);

      // Backpressure on AR, R and the IFU response
      do_fetch(32'ha000_0104, 3, 1, -1, 4, -1, 32'h2000, d, r, lat);
      chk("bp_ar_cycles", 32'(ar_cnt), 32'd4);
      chk("bp_ar_stable", 32'(ar_unstable), 32'd0);
      chk("bp_araddr", ar_addr_obs, 32'ha000_0100);
      chk("bp_wcnt", 32'(wr_cnt), 32'd8);
      chk("bp_spurious_w", 32'(spur_cnt), 32'd0);
      for (int i = 0; i < 8; i++)
         chk("bp_awaddr", wr_addr[i], 32'h100 + 32'(4 * i));
      chk("bp_rdata", d, 32'h2001);

      // Error response on beat 3
      do_fetch(32'ha000_0040, 0, 0, 3, 0, -1, 32'h3000, d, r, lat);
      chk("err_wcnt", 32'(wr_cnt), 32'd8);
      chk("err_wdata3", wr_data[3], 32'h3003);
      chk("err_rresp", r, 2'b10);
      chk("err_rdata", d, 32'h3000);

      // Reset after five beats, then normal fetches
      do_fetch(32'ha000_0060, 0, 0, -1, 0, 5, 32'h4000, d, r, lat);
      chk("rst_mid_wcnt", 32'(wr_cnt), 32'd5);
      icache_hit = 1'b1; icache_rdata = 32'h0000_0055;
      do_fetch(32'ha000_0064, 0, 0, -1, 0, -1, 32'h0, d, r, lat);
      chk("post_rst_lat", 32'(lat), 32'd2);
      chk("post_rst_rdata", d, 32'h55);
      icache_hit = 1'b0;
      do_fetch(32'h8000_0000, 0, 0, 0, 0, -1, 32'h9900, d, r, lat);
      chk("post_rst_byp", d, 32'h9900);
      chk("post_rst_resp", r, 2'b10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
